clk_div_cfg: RTL and testbench

Configuration front-end for the clock divider, directly upstream of it. Accepts a requested integer divide ratio over a valid/ready handshake, validates it, converts it to the divider's prescaler encoding, and applies it glitch-free: it holds the divider in reset while the prescaler changes, then waits a settle window before reporting completion. Sits between the CSR/control logic and the divider instance, in the source clock domain.

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_div_cfg.sv | 120 ++++++++++++
 tb/tb_clk_div_cfg.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and ratio conversion helpers for the clock divider configuration front-end.
package clk_div_pkg;

    localparam int unsigned PRESCALER_WIDTH_DFLT = 16;

    // Conversion helpers work on a fixed 33-bit ratio, covering prescalers up to 32 bits.
    localparam int unsigned DIV_CALC_WIDTH = 33;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE,
        DONE
    } cfg_state_t;

    function automatic logic div_is_valid(input logic [DIV_CALC_WIDTH-1:0] div);
        return (div != '0) && !div[0];
    endfunction

    // Divider holds each level prescaler+1 cycles, so N = 2*(prescaler+1).
    function automatic logic [DIV_CALC_WIDTH-2:0] div_to_prescaler(input logic [DIV_CALC_WIDTH-1:0] div);
        return div[DIV_CALC_WIDTH-1:1] - 32'd1;
    endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Accepts a divide ratio, validates it, and applies the derived prescaler to the divider
// glitch-free by holding the divider in reset, then waiting a settle window before done.
module clk_div_cfg
    import clk_div_pkg::*;
#(
    parameter int unsigned PRESCALER_WIDTH   = PRESCALER_WIDTH_DFLT,
    parameter int unsigned DEFAULT_PRESCALER = 0,
    parameter int unsigned RST_CYCLES        = 2,
    parameter int unsigned SETTLE_CYCLES     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [PRESCALER_WIDTH:0]   cfg_div,
    output logic [PRESCALER_WIDTH-1:0] prescaler,
    output logic                       div_rst,
    output logic                       busy,
    output logic                       cfg_done,
    output logic                       cfg_err
);

    localparam int unsigned CNT_MAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]           RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]           SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
    localparam logic [PRESCALER_WIDTH-1:0] PRESC_RST   = PRESCALER_WIDTH'(DEFAULT_PRESCALER);

    cfg_state_t                 state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [PRESCALER_WIDTH-1:0] prescaler_q, prescaler_d;
    logic                       div_rst_q, div_rst_d;
    logic                       err_q, err_d;

    logic [DIV_CALC_WIDTH-1:0]  div_ext;
    logic                       div_ok;
    logic [PRESCALER_WIDTH-1:0] presc_new;
    logic                       accept;

    assign div_ext   = DIV_CALC_WIDTH'(cfg_div);
    assign div_ok    = div_is_valid(div_ext);
    assign presc_new = PRESCALER_WIDTH'(div_to_prescaler(div_ext));

    // div_rst_q is only high in IDLE for the first cycle after reset, keeping ready low then.
    assign cfg_ready = (state_q == IDLE) && !div_rst_q;
    assign busy      = (state_q != IDLE);
    assign cfg_done  = (state_q == DONE);
    assign cfg_err   = err_q;
    assign prescaler = prescaler_q;
    assign div_rst   = div_rst_q;
    assign accept    = cfg_valid && cfg_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            prescaler_q <= PRESC_RST;
            div_rst_q   <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prescaler_q <= prescaler_d;
            div_rst_q   <= div_rst_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        prescaler_d = prescaler_q;
        div_rst_d   = div_rst_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                div_rst_d = 1'b0;
                if (accept) begin
                    if (div_ok) begin
                        state_d     = APPLY;
                        cnt_d       = '0;
                        prescaler_d = presc_new;
                        div_rst_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            APPLY: begin
                if (cnt_q == RST_LAST) begin
                    state_d   = SETTLE;
                    cnt_d     = '0;
                    div_rst_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            // First SETTLE cycle is the one where div_rst is already low; the window follows it.
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_clk_div_cfg.sv
// Self-checking bench for clk_div_cfg: vector table, corner-case sequences, random model run.
module tb_clk_div_cfg;

    localparam int unsigned PW     = 16;
    localparam int unsigned DEF_P  = 0;
    localparam int unsigned RC     = 2;
    localparam int unsigned SC     = 4;
    localparam int unsigned DONE_J = RC + SC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [PW:0]   cfg_div = '0;
    logic          cfg_ready;
    logic [PW-1:0] prescaler;
    logic          div_rst;
    logic          busy;
    logic          cfg_done;
    logic          cfg_err;

    int total = 0;
    int bad   = 0;

    clk_div_cfg #(
        .PRESCALER_WIDTH  (PW),
        .DEFAULT_PRESCALER(DEF_P),
        .RST_CYCLES       (RC),
        .SETTLE_CYCLES    (SC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_div  (cfg_div),
        .prescaler(prescaler),
        .div_rst  (div_rst),
        .busy     (busy),
        .cfg_done (cfg_done),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200us;
        $display("FAIL global_timeout: got=running want=finished");
        $fatal(1, "bench timeout");
    end

    typedef struct {
        int unsigned div;
        bit          exp_err;
        int unsigned exp_presc;
    } vec_t;

    // status packing: {div_rst, busy, cfg_done, cfg_ready, cfg_err}
    function automatic logic [4:0] status();
        return {div_rst, busy, cfg_done, cfg_ready, cfg_err};
    endfunction

    function automatic logic [4:0] exp_st(bit drst, bit bsy, bit dn, bit rdy, bit er);
        return {drst, bsy, dn, rdy, er};
    endfunction

    function automatic bit model_valid(int unsigned n);
        return (n != 0) && (n % 2 == 0);
    endfunction

    function automatic int unsigned model_presc(int unsigned n);
        return n / 2 - 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int unsigned w;
        w = 0;
        while (cfg_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_ready"}, 32'(cfg_ready), 32'd1);
    endtask

    task automatic run_req(input string tag, input int unsigned n, input bit exp_err,
                           input int unsigned exp_p);
        wait_ready(tag);
        cfg_div   = (PW+1)'(n);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        if (exp_err) begin
            check({tag, "_err_st"}, 32'(status()), 32'(exp_st(0, 0, 0, 1, 1)));
            check({tag, "_err_presc"}, 32'(prescaler), exp_p);
            @(negedge clk);
            check({tag, "_err_clr"}, 32'(status()), 32'(exp_st(0, 0, 0, 1, 0)));
        end else begin
            for (int unsigned j = 0; j <= DONE_J + 1; j++) begin
                if (j > 0) @(negedge clk);
                check($sformatf("%s_st%0d", tag, j), 32'(status()),
                      32'(exp_st(j < RC, j <= DONE_J, j == DONE_J, j > DONE_J, 0)));
                check($sformatf("%s_presc%0d", tag, j), 32'(prescaler), exp_p);
            end
        end
    endtask

    initial begin
        vec_t        vecs[$];
        int          dones;
        int          errs;
        int unsigned w;
        int          acc_e;
        int          rej_e;
        int          d;
        bit          act;
        int unsigned cur_p;
        int unsigned n;

        // reset behaviour
        #12;
        check("rst_st", 32'(status()), 32'(exp_st(1, 0, 0, 0, 0)));
        check("rst_presc", 32'(prescaler), DEF_P);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rel_pre_edge", 32'(status()), 32'(exp_st(1, 0, 0, 0, 0)));
        @(negedge clk);
        check("rel_post_edge", 32'(status()), 32'(exp_st(0, 0, 0, 1, 0)));
        check("rel_presc", 32'(prescaler), DEF_P);

        // vector table: ratio, expected reject, expected prescaler afterwards
        vecs.push_back('{8,      0, 3});
        vecs.push_back('{7,      1, 3});
        vecs.push_back('{0,      1, 3});
        vecs.push_back('{131070, 0, 32'hFFFE});
        vecs.push_back('{131071, 1, 32'hFFFE});
        vecs.push_back('{2,      0, 0});
        vecs.push_back('{2,      0, 0});
        vecs.push_back('{4,      0, 1});
        vecs.push_back('{100,    0, 49});
        for (int i = 0; i < vecs.size(); i++)
            run_req($sformatf("vec%0d", i), vecs[i].div, vecs[i].exp_err, vecs[i].exp_presc);

        // request held through a busy window: ignored until ready, then accepted once
        wait_ready("hold");
        cfg_div   = (PW+1)'(8);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_div = (PW+1)'(4);
        dones = 0;
        errs  = 0;
        for (int unsigned j = 0; j <= DONE_J + 1; j++) begin
            if (j > 0) @(negedge clk);
            dones += int'(cfg_done);
            errs  += int'(cfg_err);
            check($sformatf("hold_st%0d", j), 32'(status()),
                  32'(exp_st(j < RC, j <= DONE_J, j == DONE_J, j > DONE_J, 0)));
        end
        check("hold_first_dones", 32'(dones), 32'd1);
        @(negedge clk);
        cfg_valid = 1'b0;
        check("hold_second_accept", 32'(status()), 32'(exp_st(1, 1, 0, 0, 0)));
        check("hold_second_presc", 32'(prescaler), 32'd1);
        w = 0;
        dones = 0;
        while (cfg_done !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
            errs += int'(cfg_err);
        end
        check("hold_second_latency", 32'(w), DONE_J);
        check("hold_errs", 32'(errs), 32'd0);
        @(negedge clk);
        dones += int'(cfg_done);
        check("hold_single_done", 32'(dones), 32'd0);

        // asynchronous reset in the middle of SETTLE
        wait_ready("mid");
        cfg_div   = (PW+1)'(8);
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
        repeat (RC + 1) @(negedge clk);
        check("mid_in_settle", 32'(status()), 32'(exp_st(0, 1, 0, 0, 0)));
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_st", 32'(status()), 32'(exp_st(1, 0, 0, 0, 0)));
        check("mid_rst_presc", 32'(prescaler), DEF_P);
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dones += int'(cfg_done);
        end
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dones += int'(cfg_done);
        end
        check("mid_no_done", 32'(dones), 32'd0);
        check("mid_idle", 32'(status()), 32'(exp_st(0, 0, 0, 1, 0)));
        run_req("post_rst", 6, 0, 2);

        // random requests against a schedule-based model
        cur_p = 2;
        acc_e = -1000;
        rej_e = -1000;
        for (int e = 0; e < 600; e++) begin
            d   = e - acc_e;
            act = (d >= 0) && (d <= int'(DONE_J));
            check($sformatf("rand_st%0d", e), 32'(status()),
                  32'(exp_st((d >= 0) && (d < int'(RC)), act, d == int'(DONE_J), !act, rej_e == e)));
            check($sformatf("rand_presc%0d", e), 32'(prescaler), cur_p);
            case ($urandom_range(0, 3))
                0:       n = 0;
                1:       n = $urandom_range(0, 65535) * 2 + 1;
                2:       n = $urandom_range(1, 32) * 2;
                default: n = $urandom_range(1, 65535) * 2;
            endcase
            cfg_div   = (PW+1)'(n);
            cfg_valid = ($urandom_range(0, 2) != 0);
            if (cfg_valid && !act) begin
                if (model_valid(n)) begin
                    acc_e = e + 1;
                    cur_p = model_presc(n);
                end else begin
                    rej_e = e + 1;
                end
            end
            @(negedge clk);
        end
        cfg_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
